// File: rtl/lu_pkg.sv
// lu_pkg: shared definitions for the logic_unit_mc execution unit.
//   - lu_op_e    : 4-bit operation codes
//   - lu_state_e : control FSM states
//   - ROTATE_EN  : set when LU_ROTATE_EN is defined (iterative ROL/ROR)
//   - is_shift_op(), is_rotate_op() : op classification helpers
// Build macro: LU_ROTATE_EN. When it is undefined, ROL/ROR are reported as
// illegal and finish in one cycle.
package lu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOR   = 4'd5,
        OP_SLT   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_PASSA = 4'd8,
        OP_SLL   = 4'd9,
        OP_SRL   = 4'd10,
        OP_SRA   = 4'd11,
        OP_ROL   = 4'd12,
        OP_ROR   = 4'd13,
        OP_BEQ   = 4'd14,
        OP_BNE   = 4'd15
    } lu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } lu_state_e;

`ifdef LU_ROTATE_EN
    localparam bit ROTATE_EN = 1'b1;
`else
    localparam bit ROTATE_EN = 1'b0;
`endif

    function automatic logic is_rotate_op(input logic [3:0] op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

    // Ops that go through the iterative shifter (when the amount is non-zero).
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
               (ROTATE_EN && is_rotate_op(op));
    endfunction

endpackage

// File: rtl/lu_iter_shifter.sv
// lu_iter_shifter: iterative shifter/rotator used by logic_unit_mc.
// Shifts a captured operand by up to SHIFT_STEP bits per enabled cycle until
// the remaining amount is exhausted.
// Ports:
//   clk, reset   clock / asynchronous active-high reset
//   load         capture data_in, amount and the shift kind decoded from op
//   step_en      perform one step this cycle
//   op           operation code (SLL/SRL/SRA/ROL/ROR)
//   data_in      operand to shift
//   amount       total shift amount (non-zero when load is used)
//   shreg_next   value the register will hold after the current step
//   last_step    current step consumes the remaining amount
module lu_iter_shifter
    import lu_pkg::*;
#(
    parameter  int W          = 32,
    parameter  int SHIFT_STEP = 1,
    localparam int SAW        = $clog2(W)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step_en,
    input  logic [3:0]     op,
    input  logic [W-1:0]   data_in,
    input  logic [SAW-1:0] amount,
    output logic [W-1:0]   shreg_next,
    output logic           last_step
);

    localparam logic [SAW-1:0] STEP_AMT = SAW'(SHIFT_STEP);

    logic [W-1:0]   shreg_q, shreg_d;
    logic [SAW-1:0] rem_q, rem_d;
    logic           left_q, left_d;
    logic           arith_q, arith_d;
    logic           rotate_q, rotate_d;

    logic [SAW-1:0] k;
    logic [SAW-1:0] k_inv;
    logic [W-1:0]   step_val;

    always_comb begin
        k     = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
        // W-k modulo W; k is never 0 while stepping, so the wrap term is exact.
        k_inv = '0 - k;
        if (left_q) begin
            if (rotate_q) step_val = (shreg_q << k) | (shreg_q >> k_inv);
            else          step_val = shreg_q << k;
        end else begin
            if (rotate_q)     step_val = (shreg_q >> k) | (shreg_q << k_inv);
            else if (arith_q) step_val = $signed(shreg_q) >>> k;
            else              step_val = shreg_q >> k;
        end
    end

    assign shreg_next = step_val;
    assign last_step  = (rem_q <= STEP_AMT);

    always_comb begin
        shreg_d  = shreg_q;
        rem_d    = rem_q;
        left_d   = left_q;
        arith_d  = arith_q;
        rotate_d = rotate_q;
        if (load) begin
            shreg_d  = data_in;
            rem_d    = amount;
            left_d   = (op == OP_SLL) || (op == OP_ROL);
            arith_d  = (op == OP_SRA);
            rotate_d = is_rotate_op(op);
        end else if (step_en) begin
            shreg_d = step_val;
            rem_d   = rem_q - k;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q  <= '0;
            rem_q    <= '0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
            rotate_q <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            rem_q    <= rem_d;
            left_q   <= left_d;
            arith_q  <= arith_d;
            rotate_q <= rotate_d;
        end
    end

endmodule

// File: rtl/logic_unit_mc.sv
// logic_unit_mc: multicycle execution unit (ALU, shifts, set-less-than,
// branch compare) behind a start/done handshake.
// Build macro: LU_ROTATE_EN enables iterative ROL/ROR; otherwise they are
// reported through illegal_op.
// Ports:
//   clk, reset        clock / asynchronous active-high reset
//   start             launch an op (only sampled in IDLE)
//   op                operation code (lu_pkg::lu_op_e)
//   src_a, src_b      operands (src_b is the shifted operand)
//   shamt, amt_sel    shift amount: shamt, or src_a[SAW-1:0] when amt_sel=1
//   busy, done        handshake status; done is a one-cycle pulse
//   result, overflow, zero, negative, branch_tk, illegal_op
//                     registered result and flags, valid from done to next done
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_SHIFT | iterative shifter running, SHIFT_STEP bits per cycle
// ST_FIN   | result/flags registered, done asserted for this cycle
module logic_unit_mc
    import lu_pkg::*;
#(
    parameter  int W          = 32,
    parameter  int SHIFT_STEP = 1,
    localparam int SAW        = $clog2(W)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [3:0]     op,
    input  logic [W-1:0]   src_a,
    input  logic [W-1:0]   src_b,
    input  logic [SAW-1:0] shamt,
    input  logic           amt_sel,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   result,
    output logic           overflow,
    output logic           zero,
    output logic           negative,
    output logic           branch_tk,
    output logic           illegal_op
);

    lu_state_e state_q, state_d;

    logic [W-1:0] result_q, result_d;
    logic         overflow_q, overflow_d;
    logic         zero_q, zero_d;
    logic         negative_q, negative_d;
    logic         branch_tk_q, branch_tk_d;
    logic         illegal_q, illegal_d;

    logic [SAW-1:0] amount;
    logic           launch_shift;
    logic           launch_single;
    logic           shift_active;
    logic [W-1:0]   shreg_next;
    logic           last_step;

    logic [W-1:0] sum, diff;
    logic [W-1:0] alu_res;
    logic         alu_ovf, alu_br, alu_ill;

    assign amount        = amt_sel ? src_a[SAW-1:0] : shamt;
    assign launch_shift  = (state_q == ST_IDLE) && start && is_shift_op(op) && (amount != '0);
    assign launch_single = (state_q == ST_IDLE) && start && !launch_shift;
    assign shift_active  = (state_q == ST_SHIFT);

    // Single-cycle datapath; shift ops only land here with a zero amount.
    always_comb begin
        sum     = src_a + src_b;
        diff    = src_a - src_b;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_br  = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (src_a[W-1] == src_b[W-1]) && (sum[W-1] != src_a[W-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (src_a[W-1] != src_b[W-1]) && (diff[W-1] != src_a[W-1]);
            end
            OP_AND:   alu_res = src_a & src_b;
            OP_OR:    alu_res = src_a | src_b;
            OP_XOR:   alu_res = src_a ^ src_b;
            OP_NOR:   alu_res = ~(src_a | src_b);
            OP_SLT:   alu_res = {{(W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU:  alu_res = {{(W-1){1'b0}}, (src_a < src_b)};
            OP_PASSA: alu_res = src_a;
            OP_SLL, OP_SRL, OP_SRA: alu_res = src_b;
            OP_ROL, OP_ROR: begin
                if (ROTATE_EN) alu_res = src_b;
                else           alu_ill = 1'b1;
            end
            OP_BEQ: begin
                alu_res = diff;
                alu_br  = (src_a == src_b);
            end
            OP_BNE: begin
                alu_res = diff;
                alu_br  = (src_a != src_b);
            end
            default: alu_res = '0;
        endcase
    end

    lu_iter_shifter #(
        .W          (W),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load       (launch_shift),
        .step_en    (shift_active),
        .op         (op),
        .data_in    (src_b),
        .amount     (amount),
        .shreg_next (shreg_next),
        .last_step  (last_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_shift)       state_d = ST_SHIFT;
                else if (launch_single) state_d = ST_FIN;
            end
            ST_SHIFT: if (last_step) state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_FIN);
    end

    // Result registers load on the same edge that enters FIN, so they stay
    // stable through done and until the next op completes.
    always_comb begin
        result_d    = result_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        negative_d  = negative_q;
        branch_tk_d = branch_tk_q;
        illegal_d   = illegal_q;
        if (launch_single) begin
            result_d    = alu_res;
            overflow_d  = alu_ovf;
            zero_d      = (alu_res == '0);
            negative_d  = alu_res[W-1];
            branch_tk_d = alu_br;
            illegal_d   = alu_ill;
        end else if (shift_active && last_step) begin
            result_d    = shreg_next;
            overflow_d  = 1'b0;
            zero_d      = (shreg_next == '0);
            negative_d  = shreg_next[W-1];
            branch_tk_d = 1'b0;
            illegal_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q    <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            branch_tk_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            branch_tk_q <= branch_tk_d;
            illegal_q   <= illegal_d;
        end
    end

    assign result     = result_q;
    assign overflow   = overflow_q;
    assign zero       = zero_q;
    assign negative   = negative_q;
    assign branch_tk  = branch_tk_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_logic_unit_mc.sv
// Testbench for logic_unit_mc: two instances (SHIFT_STEP=1 and SHIFT_STEP=4),
// directed and randomized ops checked against an arithmetic reference model.
module tb_logic_unit_mc;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start4;
    logic [3:0]  op;
    logic [31:0] src_a, src_b;
    logic [4:0]  shamt;
    logic        amt_sel;

    logic        busy1, done1, ovf1, zero1, neg1, br1, ill1;
    logic [31:0] result1;
    logic        busy4, done4, ovf4, zero4, neg4, br4, ill4;
    logic [31:0] result4;

    logic        use4;
    logic        o_busy, o_done, o_ovf, o_zero, o_neg, o_br, o_ill;
    logic [31:0] o_result;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic_unit_mc #(.W(32), .SHIFT_STEP(1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .shamt(shamt), .amt_sel(amt_sel), .busy(busy1), .done(done1), .result(result1),
        .overflow(ovf1), .zero(zero1), .negative(neg1), .branch_tk(br1), .illegal_op(ill1)
    );

    logic_unit_mc #(.W(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op), .src_a(src_a), .src_b(src_b),
        .shamt(shamt), .amt_sel(amt_sel), .busy(busy4), .done(done4), .result(result4),
        .overflow(ovf4), .zero(zero4), .negative(neg4), .branch_tk(br4), .illegal_op(ill4)
    );

    assign o_busy   = use4 ? busy4   : busy1;
    assign o_done   = use4 ? done4   : done1;
    assign o_result = use4 ? result4 : result1;
    assign o_ovf    = use4 ? ovf4    : ovf1;
    assign o_zero   = use4 ? zero4   : zero1;
    assign o_neg    = use4 ? neg4    : neg1;
    assign o_br     = use4 ? br4     : br1;
    assign o_ill    = use4 ? ill4    : ill1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: results from plain arithmetic, latency from the step count.
    function automatic void model(input logic [3:0] m_op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, input logic sel, input int step,
                                  output logic [31:0] r, output logic ovf, output logic br,
                                  output logic ill, output int lat);
        int     amt;
        longint sa, sb, s;
        logic   iterative;
        amt = sel ? int'(a[4:0]) : int'(sh);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = 32'd0;
        ovf = 1'b0;
        br  = 1'b0;
        ill = 1'b0;
        iterative = (m_op == 4'd9) || (m_op == 4'd10) || (m_op == 4'd11);
        case (m_op)
            4'd0: begin s = sa + sb; r = a + b; ovf = (s > MAXS) || (s < MINS); end
            4'd1: begin s = sa - sb; r = a - b; ovf = (s > MAXS) || (s < MINS); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b);
            4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: r = (a < b) ? 32'd1 : 32'd0;
            4'd8: r = a;
            4'd9: r = b << amt;
            4'd10: r = b >> amt;
            4'd11: r = 32'($signed(b) >>> amt);
`ifdef LU_ROTATE_EN
            4'd12: begin r = (amt == 0) ? b : ((b << amt) | (b >> (32 - amt))); iterative = 1'b1; end
            4'd13: begin r = (amt == 0) ? b : ((b >> amt) | (b << (32 - amt))); iterative = 1'b1; end
`else
            4'd12, 4'd13: begin r = 32'd0; ill = 1'b1; end
`endif
            4'd14: begin r = a - b; br = (a == b); end
            default: begin r = a - b; br = (a != b); end
        endcase
        lat = (iterative && amt > 0) ? ((amt + step - 1) / step + 1) : 1;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] t_op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic sel,
                          input logic on4, input logic noise);
        logic [31:0] e_r;
        logic        e_ovf, e_br, e_ill;
        int          e_lat;
        int          cycles;
        logic        got;
        model(t_op, a, b, sh, sel, on4 ? 4 : 1, e_r, e_ovf, e_br, e_ill, e_lat);
        @(negedge clk);
        use4    = on4;
        op      = t_op;
        src_a   = a;
        src_b   = b;
        shamt   = sh;
        amt_sel = sel;
        if (on4) start4 = 1'b1;
        else     start  = 1'b1;
        @(posedge clk);
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 100) begin
            @(negedge clk);
            start  = 1'b0;
            start4 = 1'b0;
            cycles++;
            if (o_done) got = 1'b1;
            else if (noise) begin
                start   = 1'($urandom);
                op      = 4'($urandom);
                src_a   = $urandom;
                src_b   = $urandom;
                shamt   = 5'($urandom);
                amt_sel = 1'($urandom);
            end
        end
        check({tag, "_latency"}, cycles, e_lat);
        check({tag, "_result"},  o_result, e_r);
        check({tag, "_overflow"}, 32'(o_ovf), 32'(e_ovf));
        check({tag, "_zero"},    32'(o_zero), 32'(e_r == 32'd0));
        check({tag, "_negative"}, 32'(o_neg), 32'(e_r[31]));
        check({tag, "_branch"},  32'(o_br), 32'(e_br));
        check({tag, "_illegal"}, 32'(o_ill), 32'(e_ill));
        check({tag, "_busy_at_done"}, 32'(o_busy), 32'd1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(o_done), 32'd0);
        check({tag, "_idle_after"}, 32'(o_busy), 32'd0);
        check({tag, "_result_held"}, o_result, e_r);
    endtask

    initial begin
        int ndone;
        reset   = 1'b1;
        start   = 1'b0;
        start4  = 1'b0;
        use4    = 1'b0;
        op      = 4'd0;
        src_a   = 32'd0;
        src_b   = 32'd0;
        shamt   = 5'd0;
        amt_sel = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy",   32'(busy1), 32'd0);
        check("reset_done",   32'(done1), 32'd0);
        check("reset_result", result1, 32'd0);
        check("reset_flags",  32'({ovf1, zero1, neg1, br1, ill1}), 32'd0);
        check("reset4_state", 32'({busy4, done4, ovf4, zero4, neg4, br4, ill4}), 32'd0);
        reset = 1'b0;

        run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("add_ovf_lit", o_result, 32'h8000_0000);
        check("add_ovf_flag", 32'(o_ovf), 32'd1);
        run_op("sub_eq", 4'd1, 32'd5, 32'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        check("sub_eq_zero", 32'(o_zero), 32'd1);
        run_op("beq_eq", 4'd14, 32'd5, 32'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        check("beq_taken", 32'(o_br), 32'd1);
        run_op("bne_eq", 4'd15, 32'd5, 32'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        check("bne_not_taken", 32'(o_br), 32'd0);
        run_op("sra4", 4'd11, 32'd0, 32'h8000_0000, 5'd4, 1'b0, 1'b0, 1'b1);
        check("sra4_lit", o_result, 32'hF800_0000);
        run_op("sll_step4", 4'd9, 32'h23, 32'd1, 5'd0, 1'b1, 1'b1, 1'b0);
        check("sll_step4_lit", o_result, 32'd8);
        run_op("slt", 4'd6, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("slt_lit", o_result, 32'd1);
        run_op("sltu", 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("sltu_lit", o_result, 32'd0);
        run_op("sll_amt0", 4'd9, 32'h40, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b0);
        check("sll_amt0_lit", o_result, 32'hDEAD_BEEF);
        run_op("srl31", 4'd10, 32'd0, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 1'b0);
        check("srl31_lit", o_result, 32'd1);
        run_op("sra31_step4", 4'd11, 32'd0, 32'h8000_0000, 5'd31, 1'b0, 1'b1, 1'b0);
        check("sra31_step4_lit", o_result, 32'hFFFF_FFFF);
        run_op("ror1", 4'd13, 32'd0, 32'd1, 5'd1, 1'b0, 1'b0, 1'b0);
`ifdef LU_ROTATE_EN
        check("ror1_lit", o_result, 32'h8000_0000);
        check("ror1_legal", 32'(o_ill), 32'd0);
`else
        check("ror1_lit", o_result, 32'd0);
        check("ror1_illegal", 32'(o_ill), 32'd1);
`endif

        for (int i = 0; i < 40; i++) begin
            logic on4;
            on4 = 1'($urandom);
            run_op($sformatf("rand%0d", i), 4'($urandom), $urandom, $urandom,
                   5'($urandom), 1'($urandom), on4, on4 ? 1'b0 : 1'($urandom));
        end

        // Abort a shift with reset and confirm no stray done afterwards.
        run_op("pre_reset", 4'd8, 32'h0000_1234, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        use4    = 1'b0;
        op      = 4'd10;
        src_b   = 32'hFFFF_FFFF;
        shamt   = 5'd20;
        amt_sel = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_shift_busy", 32'(busy1), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy",   32'(busy1), 32'd0);
        check("abort_done",   32'(done1), 32'd0);
        check("abort_result", result1, 32'd0);
        check("abort_flags",  32'({ovf1, zero1, neg1, br1, ill1}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_op("post_reset", 4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
